// File: rtl/fifo.sv
// rtl/fifo.sv - synchronous first-word-fall-through FIFO with async clear
//
// Purpose: single-clock FIFO holding 2**FIFO_DEPTH words of DATA_WIDTH bits.
//   The oldest word is always presented on DOUT (zero-wait fall-through);
//   DOUT reads as zero while the FIFO is empty.
// Ports:
//   CLK   in   clock, all state updates on rising edge
//   CLR   in   asynchronous active-high clear (empties the FIFO)
//   nWE   in   active-low write request, DIN sampled when accepted
//   DIN   in   write data
//   FULL  out  2**FIFO_DEPTH words stored
//   nRE   in   active-low pop request
//   DOUT  out  oldest stored word, or zero when empty
//   EMPTY out  no words stored
//   LEVEL out  registered stored-word count (only with FIFO_LEVEL_EN)
// Configuration: define FIFO_LEVEL_EN to add the LEVEL port and its register.

module fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  nWE,
  input  logic [DATA_WIDTH-1:0] DIN,
  output logic                  FULL,
  input  logic                  nRE,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  EMPTY
`ifdef FIFO_LEVEL_EN
  ,
  output logic [FIFO_DEPTH:0]   LEVEL
`endif
);

  localparam int PW = FIFO_DEPTH + 1;
  localparam int ENTRIES = 1 << FIFO_DEPTH;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [ENTRIES];
  logic                  wr_en;
  logic                  rd_en;

  // Flags depend only on registered pointers, so no input reaches an output
  // combinationally. The extra MSB separates full from empty.
  assign EMPTY = (wr_ptr_q == rd_ptr_q);
  assign FULL  = (wr_ptr_q[FIFO_DEPTH-1:0] == rd_ptr_q[FIFO_DEPTH-1:0]) &&
                 (wr_ptr_q[FIFO_DEPTH] != rd_ptr_q[FIFO_DEPTH]);

  // Acceptance uses the pre-edge flags: a pop on an empty FIFO or a write on
  // a full one is dropped even if the other side moves on the same edge.
  assign wr_en = !nWE && !FULL && !CLR;
  assign rd_en = !nRE && !EMPTY && !CLR;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage has no reset so it can map onto RAM with asynchronous read.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q[FIFO_DEPTH-1:0]] <= DIN;
  end

  // Zero on empty keeps stale RAM contents off the output bus.
  assign DOUT = EMPTY ? '0 : mem_q[rd_ptr_q[FIFO_DEPTH-1:0]];

`ifdef FIFO_LEVEL_EN
  logic [PW-1:0] level_q, level_d;

  // Modular pointer difference gives 0..2**FIFO_DEPTH without wrap handling.
  always_comb begin
    level_d = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) level_q <= '0;
    else     level_q <= level_d;
  end

  assign LEVEL = level_q;
`endif

endmodule

// File: tb/tb_fifo.sv
// tb/tb_fifo.sv - self-checking bench for fifo (FIFO_DEPTH=2, DATA_WIDTH=32)

module tb_fifo;

  localparam int D  = 2;
  localparam int W  = 32;
  localparam int CAP = 1 << D;

  logic         CLK = 1'b0;
  logic         CLR = 1'b1;
  logic         nWE = 1'b1;
  logic         nRE = 1'b1;
  logic [W-1:0] DIN = '0;
  logic         FULL;
  logic         EMPTY;
  logic [W-1:0] DOUT;
`ifdef FIFO_LEVEL_EN
  logic [D:0]   LEVEL;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fifo #(.FIFO_DEPTH(D), .DATA_WIDTH(W)) dut (
    .CLK   (CLK),
    .CLR   (CLR),
    .nWE   (nWE),
    .DIN   (DIN),
    .FULL  (FULL),
    .nRE   (nRE),
    .DOUT  (DOUT),
    .EMPTY (EMPTY)
`ifdef FIFO_LEVEL_EN
    ,
    .LEVEL (LEVEL)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words, updated from pre-edge occupancy.
  logic [W-1:0] model_q[$];
  bit m_w, m_r;

  always @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      model_q.delete();
    end else begin
      m_w = !nWE && (model_q.size() < CAP);
      m_r = !nRE && (model_q.size() > 0);
      if (m_r) void'(model_q.pop_front());
      if (m_w) model_q.push_back(DIN);
    end
  end

  // Continuous comparison on every falling edge.
  always @(negedge CLK) begin
    check("cmp_empty", W'(EMPTY), W'(model_q.size() == 0));
    check("cmp_full",  W'(FULL),  W'(model_q.size() == CAP));
    check("cmp_dout",  DOUT, (model_q.size() == 0) ? '0 : model_q[0]);
`ifdef FIFO_LEVEL_EN
    check("cmp_level", W'(LEVEL), W'(model_q.size()));
`endif
  end

  // Drive one cycle's inputs just after a falling edge.
  task automatic drive(input logic we_n, input logic re_n, input logic [W-1:0] d);
    @(negedge CLK);
    nWE = we_n;
    nRE = re_n;
    DIN = d;
  endtask

  task automatic check_level(input string name, input int exp);
`ifdef FIFO_LEVEL_EN
    check(name, W'(LEVEL), W'(exp));
`else
    check(name, W'(model_q.size()), W'(exp));
`endif
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_empty", W'(EMPTY), 1);
    check("rst_full",  W'(FULL),  0);
    check("rst_dout",  DOUT, 0);
    @(negedge CLK);
    CLR = 1'b0;

    // Fill: 0x11..0x44
    drive(1'b0, 1'b1, 32'h11);
    drive(1'b0, 1'b1, 32'h22);
    drive(1'b0, 1'b1, 32'h33);
    drive(1'b0, 1'b1, 32'h44);
    drive(1'b0, 1'b1, 32'h55);      // this edge sees FULL, write dropped
    check("fill_full",  W'(FULL), 1);
    check("fill_dout",  DOUT, 32'h11);
    check_level("fill_level", 4);

    // Pop four, consumer reads DOUT in the cycle it pops
    drive(1'b1, 1'b0, '0);
    check("pop0", DOUT, 32'h11);
    drive(1'b1, 1'b0, '0);
    check("pop1", DOUT, 32'h22);
    drive(1'b1, 1'b0, '0);
    check("pop2", DOUT, 32'h33);
    drive(1'b1, 1'b0, '0);
    check("pop3", DOUT, 32'h44);
    drive(1'b1, 1'b1, '0);
    check("drain_empty", W'(EMPTY), 1);
    check("drain_dout",  DOUT, 0);

    // Simultaneous write+pop on empty: write only
    nWE = 1'b0; nRE = 1'b0; DIN = 32'hA5;
    drive(1'b1, 1'b1, '0);
    check("sim_empty", W'(EMPTY), 0);
    check("sim_dout",  DOUT, 32'hA5);
    check_level("sim_level", 1);

    // Second word, then 10 write+pop edges across pointer wrap
    nWE = 1'b0; DIN = 32'h100;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 32'h200 + 32'(i));
      if (i == 0) check("wrap_first", DOUT, 32'hA5);
      if (i == 1) check("wrap_second", DOUT, 32'h100);
      if (i >= 2) check("wrap_order", DOUT, 32'h200 + 32'(i - 2));
      check_level("wrap_level", 2);
    end
    drive(1'b0, 1'b1, 32'h300);     // third word
    drive(1'b1, 1'b1, '0);
    check_level("three_level", 3);
    check("three_dout", DOUT, 32'h208);

    // Asynchronous clear between edges
    #2 CLR = 1'b1;
    #1;
    check("aclr_empty", W'(EMPTY), 1);
    check("aclr_full",  W'(FULL),  0);
    check("aclr_dout",  DOUT, 0);
    #1 CLR = 1'b0;

    // Pop on empty for three edges, then a write
    drive(1'b1, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 32'h7E);
    drive(1'b1, 1'b1, '0);
    check("post_empty", W'(EMPTY), 0);
    check("post_dout",  DOUT, 32'h7E);
    check_level("post_level", 1);

    drive(1'b1, 1'b1, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
- REQ-001: Parameter FIFO_DEPTH, default 4; log2 of entry count; storage holds 2**FIFO_DEPTH words; legal range 1..12.
- REQ-002: Parameter DATA_WIDTH, default 32; word width in bits; legal range 1..1024.
- REQ-003: CLK  input  1  single clock; all state updates on rising edge.
- REQ-004: CLR  input  1  reset, asynchronous, active-high.
- REQ-005: nWE  input  1  write request, active-low.
- REQ-006: DIN  input  DATA_WIDTH  write data, sampled with nWE=0.
- REQ-007: FULL  output  1  high when 2**FIFO_DEPTH words stored.
- REQ-008: nRE  input  1  read/pop request, active-low.
- REQ-009: DOUT  output  DATA_WIDTH  oldest stored word, first-word-fall-through.
- REQ-010: EMPTY  output  1  high when zero words stored.
- REQ-011: LEVEL  output  FIFO_DEPTH+1  stored word count; present only with FIFO_LEVEL_EN (REQ-030).

Function
- REQ-012: Write accepted on a rising edge when nWE=0 and FULL=0; DIN stored at write pointer; write pointer +1.
- REQ-013: Write with FULL=1 ignored; contents, pointers and flags unchanged; no error output.
- REQ-014: Pop accepted on a rising edge when nRE=0 and EMPTY=0; read pointer +1.
- REQ-015: Pop with EMPTY=1 ignored; pointers unchanged.
- REQ-016: Write and pop accepted on the same edge: both take effect; count unchanged; FULL/EMPTY unchanged.
- REQ-017: Write and pop on the same edge while EMPTY=1: write only; pop ignored; EMPTY falls after that edge.
- REQ-018: Write and pop on the same edge while FULL=1: pop only; write ignored; FULL falls after that edge.
- REQ-019: Pointers FIFO_DEPTH+1 bits wide; low bits address storage; MSB is a wrap bit; wrap from 2**FIFO_DEPTH-1 to 0 needs no special handling.
- REQ-020: EMPTY=1 iff read pointer equals write pointer (all bits).
- REQ-021: FULL=1 iff low bits equal and wrap bits differ.
- REQ-022: FULL and EMPTY are registered or derived only from registered pointers; no combinational path from nWE, nRE or DIN to any output.
- REQ-023: DOUT = storage[read pointer low bits] whenever EMPTY=0; DOUT = 0 whenever EMPTY=1.
- REQ-024: Latency: a word written at edge N appears on DOUT with EMPTY=0 after edge N when the FIFO was empty; zero-wait fall-through.
- REQ-025: After a pop at edge N, DOUT shows the next word after edge N; the consumer reads DOUT in the same cycle it drives nRE=0.
- REQ-026: Storage is plain memory without reset, inferable as RAM with asynchronous read.

Reset
- REQ-027: CLR=1 asynchronously clears both pointers to 0, forces EMPTY=1, FULL=0, DOUT=0, and LEVEL=0 if present.
- REQ-028: CLR asserted mid-operation discards all contents; nWE and nRE are ignored while CLR=1.
- REQ-029: First accepted write is on the first rising edge after CLR falls.

Configuration
- REQ-030: Macro FIFO_LEVEL_EN defined: LEVEL port exists, registered, equals write pointer minus read pointer modulo 2**(FIFO_DEPTH+1), range 0..2**FIFO_DEPTH.
- REQ-031: Macro FIFO_LEVEL_EN undefined: LEVEL port and logic absent; all other behaviour identical.

Verification
- REQ-032: FIFO_DEPTH=2, DATA_WIDTH=32; reset, then write 0x11,0x22,0x33,0x44 on consecutive edges -> FULL=1 after the 4th edge, LEVEL=4, DOUT=0x11.
- REQ-033: From full, write 0x55, then pop 4 times -> DOUT sequence 0x11,0x22,0x33,0x44, then EMPTY=1 and DOUT=0; 0x55 is never output.
- REQ-034: From empty, nWE=0 and nRE=0 on the same edge with DIN=0xA5 -> EMPTY=0, DOUT=0xA5, LEVEL=1.
- REQ-035: With 2 words stored, write and pop together for 10 edges with incrementing data -> LEVEL stays 2, output order preserved across pointer wrap, FULL and EMPTY stay 0.
- REQ-036: With 3 words stored, pulse CLR between clock edges -> EMPTY=1, FULL=0 and DOUT=0 immediately, without waiting for a clock edge.
- REQ-037: Pop with EMPTY=1 for 3 edges, then write 0x7E -> pointers not corrupted; DOUT=0x7E, LEVEL=1.
